imm_decode_stage: RTL

Pipelined immediate-decode stage between instruction fetch and the sign-extension/execute path. Accepts 32-bit RV32I instruction words over a valid/ready handshake, classifies the immediate format from the opcode, and assembles and sign-extends the immediate to XLEN bits. It also registers rd/rs1/rs2/funct3/funct7. Output is registered with one cycle of latency and full backpressure support.

---
 rtl/imm_decode_stage.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/imm_decode_stage.sv
// RV32I immediate decode stage: classifies the immediate format, sign-extends it to XLEN and registers the register fields.
// Latency: one cycle; an instruction accepted on edge N is presented with out_valid=1 right after edge N.
// Backpressure: valid/ready on both sides. With IMM_DECODE_SKID_EN a 2-entry skid makes in_ready registered; otherwise in_ready = !out_valid || out_ready.
module imm_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [31:0]     in_instr,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [6:0]      out_opcode,
  output logic            out_valid,
  input  logic            out_ready
);

  // Immediate format codes as seen on out_fmt.
  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  // RV32I major opcodes that carry an immediate.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // One decoded instruction as it is held in the output or skid register.
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [6:0]      opcode;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Register fields are copied unconditionally; only imm/fmt depend on the opcode.
  function automatic entry_t decode(input logic [31:0] i);
    entry_t e;
    e        = '0;
    e.rd     = i[11:7];
    e.rs1    = i[19:15];
    e.rs2    = i[24:20];
    e.funct3 = i[14:12];
    e.funct7 = i[31:25];
    e.opcode = i[6:0];
    case (i[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
        e.fmt = FMT_I;
        e.imm = {{(XLEN-11){i[31]}}, i[30:20]};
      end
      OP_STORE: begin
        e.fmt = FMT_S;
        e.imm = {{(XLEN-11){i[31]}}, i[30:25], i[11:7]};
      end
      OP_BRANCH: begin
        e.fmt = FMT_B;
        e.imm = {{(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        e.fmt = FMT_U;
        e.imm = {{(XLEN-31){i[31]}}, i[30:12], 12'b0};
      end
      OP_JAL: begin
        e.fmt = FMT_J;
        e.imm = {{(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      end
      default: begin
        e.fmt = FMT_NONE;
        e.imm = '0;
      end
    endcase
    return e;
  endfunction

  state_t state_q;
  state_t state_d;
  entry_t out_q;
  entry_t dec;
  logic   in_xfer;
  logic   out_xfer;
  logic   load_out_in;
`ifdef IMM_DECODE_SKID_EN
  entry_t skid_q;
  logic   load_out_skid;
  logic   load_skid;
  logic   in_ready_q;
`endif

  assign dec       = decode(in_instr);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Next-state and register load enables; flush overrides every transfer in the cycle.
  always_comb begin
    state_d     = state_q;
    load_out_in = 1'b0;
`ifdef IMM_DECODE_SKID_EN
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
`endif
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d     = ST_BUSY;
            load_out_in = 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_xfer && out_xfer) begin
            // New entry replaces the departing one; the skid stays empty.
            load_out_in = 1'b1;
`ifdef IMM_DECODE_SKID_EN
          end else if (in_xfer) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
`endif
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
`ifdef IMM_DECODE_SKID_EN
        ST_FULL: begin
          if (out_xfer) begin
            state_d       = ST_BUSY;
            load_out_skid = 1'b1;
          end
        end
`endif
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output register: fed from the decoder, or from the skid when draining FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (load_out_in) begin
      out_q <= dec;
`ifdef IMM_DECODE_SKID_EN
    end else if (load_out_skid) begin
      out_q <= skid_q;
`endif
    end
  end

`ifdef IMM_DECODE_SKID_EN
  // Skid register catches the entry accepted while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= dec;
    end
  end

  // in_ready comes straight from a flop so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  assign in_ready = in_ready_q;
`else
  assign in_ready = !out_valid || out_ready;
`endif

  assign out_imm    = out_q.imm;
  assign out_fmt    = out_q.fmt;
  assign out_rd     = out_q.rd;
  assign out_rs1    = out_q.rs1;
  assign out_rs2    = out_q.rs2;
  assign out_funct3 = out_q.funct3;
  assign out_funct7 = out_q.funct7;
  assign out_opcode = out_q.opcode;

endmodule
